rpn_stack_ctrl: RTL and testbench

Command-driven reverse-Polish evaluator that sits directly upstream of the `stack` block and drives its `Push`/`Pop`/`Data_In` while consuming `Data_Out`/`Full`/`Empty`. It accepts one command per handshake: push a literal, run a binary ALU operation on the top two entries, or pop the top entry to `Result`. It sequences the required stack pops and pushes, tracks depth, and flags underflow and overflow without touching the stack.

---
 rtl/rpn_stack_ctrl_if.sv | 27 ++
 rtl/rpn_stack_ctrl.sv | 151 +++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_stack_ctrl_if.sv
// Command/result handshake between a command source and the RPN stack controller.
// The master issues commands; the slave reports results, errors and depth.
interface rpn_stack_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic             Cmd_Valid;
  logic             Cmd_Ready;
  logic [2:0]       Cmd_Op;
  logic [WIDTH-1:0] Cmd_Data;
  logic [WIDTH-1:0] Result;
  logic             Result_Valid;
  logic             Error;
  logic [DW-1:0]    Depth;

  modport master (
    output Cmd_Valid, Cmd_Op, Cmd_Data,
    input  Cmd_Ready, Result, Result_Valid, Error, Depth
  );

  modport slave (
    input  Cmd_Valid, Cmd_Op, Cmd_Data,
    output Cmd_Ready, Result, Result_Valid, Error, Depth
  );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish command sequencer sitting in front of an external stack:
// pushes literals, runs binary ALU ops on the top two entries, pops to Result.
//
// state    | meaning
// IDLE     | ready for a command; legality checked on accept
// PUSH_LIT | St_Push with the latched literal
// POP_B    | St_Pop for the top operand (B)
// POP_A    | St_Pop for the deeper operand (A); B visible on St_Data_Out
// EXEC     | A visible on St_Data_Out; result computed and registered
// WB_PUSH  | St_Push of the result; Result_Valid pulses
// POP_OUT  | St_Pop for a POP command
// WB_OUT   | popped value visible; Result follows St_Data_Out
module rpn_stack_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  rpn_stack_ctrl_if.slave  cmd,
  output logic             St_Push,
  output logic             St_Pop,
  output logic [WIDTH-1:0] St_Data_In,
  input  logic [WIDTH-1:0] St_Data_Out,
  input  logic             St_Full,
  input  logic             St_Empty
);
  localparam int DW = $clog2(DEPTH) + 1;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {
    IDLE, PUSH_LIT, POP_B, POP_A, EXEC, WB_PUSH, POP_OUT, WB_OUT
  } state_t;

  state_t             state;
  logic [DW-1:0]      depth_q;
  logic [WIDTH-1:0]   result_q;
  logic               result_valid_q;
  logic               error_q;
  logic [WIDTH-1:0]   st_data_in_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_r;
  logic               illegal;

  assign St_Push    = (state == PUSH_LIT) || (state == WB_PUSH);
  assign St_Pop     = (state == POP_B) || (state == POP_A) || (state == POP_OUT);
  assign St_Data_In = st_data_in_q;

  assign cmd.Cmd_Ready    = (state == IDLE) && !Rst;
  assign cmd.Depth        = depth_q;
  assign cmd.Result_Valid = result_valid_q;
  assign cmd.Error        = error_q;
  // The popped word only appears on St_Data_Out in WB_OUT, so pass it straight through there.
  assign cmd.Result       = (state == WB_OUT) ? St_Data_Out : result_q;

  always_comb begin
    illegal = 1'b0;
    case (cmd.Cmd_Op)
      OP_PUSH: illegal = (depth_q == DW'(DEPTH)) || St_Full;
      OP_POP:  illegal = (depth_q == '0) || St_Empty;
      default: illegal = (depth_q < DW'(2));
    endcase
  end

  // St_Data_Out holds A during EXEC; B was captured one cycle earlier.
  assign prod = {{WIDTH{1'b0}}, St_Data_Out} * {{WIDTH{1'b0}}, b_q};

  always_comb begin
    alu_r = '0;
    case (op_q)
      OP_ADD:  alu_r = St_Data_Out + b_q;
      OP_SUB:  alu_r = St_Data_Out - b_q;
      OP_MUL:  alu_r = prod[WIDTH-1:0];
      OP_AND:  alu_r = St_Data_Out & b_q;
      OP_OR:   alu_r = St_Data_Out | b_q;
      OP_XOR:  alu_r = St_Data_Out ^ b_q;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= IDLE;
      depth_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      st_data_in_q   <= '0;
      op_q           <= OP_PUSH;
      b_q            <= '0;
    end else begin
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      if (St_Push)
        depth_q <= depth_q + DW'(1);
      else if (St_Pop)
        depth_q <= depth_q - DW'(1);

      case (state)
        IDLE: begin
          if (cmd.Cmd_Valid) begin
            op_q <= cmd.Cmd_Op;
            if (illegal) begin
              error_q <= 1'b1;
            end else begin
              case (cmd.Cmd_Op)
                OP_PUSH: begin
                  st_data_in_q <= cmd.Cmd_Data;
                  state        <= PUSH_LIT;
                end
                OP_POP:  state <= POP_OUT;
                default: state <= POP_B;
              endcase
            end
          end
        end
        PUSH_LIT: state <= IDLE;
        POP_B:    state <= POP_A;
        POP_A: begin
          b_q   <= St_Data_Out;
          state <= EXEC;
        end
        EXEC: begin
          result_q       <= alu_r;
          st_data_in_q   <= alu_r;
          result_valid_q <= 1'b1;
          state          <= WB_PUSH;
        end
        WB_PUSH: state <= IDLE;
        POP_OUT: begin
          result_valid_q <= 1'b1;
          state          <= WB_OUT;
        end
        WB_OUT: begin
          result_q <= St_Data_Out;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: behavioural stack, list-based RPN reference model,
// scoreboard of expected Result/Error events drained by an independent monitor.
module tb_rpn_stack_ctrl;
  localparam int W  = 4;
  localparam int D  = 8;
  localparam int DW = $clog2(D) + 1;
  localparam int M  = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_push, st_pop, st_full, st_empty;
  logic [W-1:0] st_data_in, st_data_out;

  always #5 clk = ~clk;

  rpn_stack_ctrl_if #(.WIDTH(W), .DEPTH(D)) cmd_if ();

  rpn_stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(clk), .Rst(rst), .cmd(cmd_if),
    .St_Push(st_push), .St_Pop(st_pop), .St_Data_In(st_data_in),
    .St_Data_Out(st_data_out), .St_Full(st_full), .St_Empty(st_empty)
  );

  // Behavioural stack: registered Data_Out, reset shares the controller's reset.
  logic [W-1:0] stk_mem [D];
  int           stk_cnt = 0;
  initial st_data_out = '0;
  always @(posedge clk) begin
    if (rst) begin
      stk_cnt     <= 0;
      st_data_out <= '0;
    end else if (st_pop && stk_cnt > 0) begin
      st_data_out <= stk_mem[stk_cnt-1];
      stk_cnt     <= stk_cnt - 1;
    end else if (st_push && stk_cnt < D) begin
      stk_mem[stk_cnt] <= st_data_in;
      stk_cnt          <= stk_cnt + 1;
    end
  end
  assign st_full  = (stk_cnt == D);
  assign st_empty = (stk_cnt == 0);

  typedef struct { bit is_err; int val; } exp_t;
  exp_t exp_q[$];
  exp_t ev;
  int   ref_q[$];
  int   held = 0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      1: return (a + b) % M;
      2: return ((a - b) % M + M) % M;
      3: return (a * b) % M;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      default: return 0;
    endcase
  endfunction

  // Monitor: every Result_Valid / Error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      check("push_pop_overlap", int'(st_push & st_pop), 0);
      if (cmd_if.Result_Valid || cmd_if.Error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", exp_q.size(), 1);
        end else begin
          ev = exp_q.pop_front();
          check("event_error", int'(cmd_if.Error), int'(ev.is_err));
          check("event_result_valid", int'(cmd_if.Result_Valid), int'(!ev.is_err));
          if (!ev.is_err) begin
            check("result", int'(cmd_if.Result), ev.val);
            held = ev.val;
          end
        end
      end else begin
        check("result_hold", int'(cmd_if.Result), held);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_cmd_ready", int'(cmd_if.Cmd_Ready), 0);
    check("rst_depth", int'(cmd_if.Depth), 0);
    check("rst_result", int'(cmd_if.Result), 0);
    check("rst_result_valid", int'(cmd_if.Result_Valid), 0);
    check("rst_error", int'(cmd_if.Error), 0);
    check("rst_st_push", int'(st_push), 0);
    check("rst_st_pop", int'(st_pop), 0);
    check("rst_st_data_in", int'(st_data_in), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_if.Cmd_Valid = 1'b0;
    exp_q.delete();
    ref_q.delete();
    held = 0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(cmd_if.Cmd_Ready), 1);
  endtask

  // Issue one command and check the cycle-by-cycle stack activity relative to
  // the accept edge. Garbage stays on the command bus while busy.
  task automatic do_cmd(input int op, input int data);
    int  sz, r, a, b, exp_ready, k, ready_k;
    bit  legal;
    bit  [8:0] pop_mask, push_mask, pop_at, push_at;
    int  din_at [9];
    sz = ref_q.size();
    r = 0; pop_mask = '0; push_mask = '0; pop_at = '0; push_at = '0;
    for (int i = 0; i < 9; i++) din_at[i] = 0;
    @(negedge clk);
    if (op == 0) begin
      legal = (sz < D);
      if (legal) begin
        r = data % M;
        ref_q.push_back(r);
        exp_ready = 2; push_mask[1] = 1'b1;
      end
    end else if (op == 7) begin
      legal = (sz > 0);
      if (legal) begin
        r = ref_q.pop_back();
        exp_q.push_back('{1'b0, r});
        exp_ready = 3; pop_mask[1] = 1'b1;
      end
    end else begin
      legal = (sz >= 2);
      if (legal) begin
        b = ref_q.pop_back();
        a = ref_q.pop_back();
        r = alu_ref(op, a, b);
        ref_q.push_back(r);
        exp_q.push_back('{1'b0, r});
        exp_ready = 5; pop_mask[1] = 1'b1; pop_mask[2] = 1'b1; push_mask[4] = 1'b1;
      end
    end
    if (!legal) begin
      exp_q.push_back('{1'b1, 0});
      exp_ready = 1;
    end
    cmd_if.Cmd_Valid = 1'b1;
    cmd_if.Cmd_Op    = 3'(op);
    cmd_if.Cmd_Data  = W'(data);
    check("accept_ready", int'(cmd_if.Cmd_Ready), 1);
    @(posedge clk);
    k = 0; ready_k = 0;
    while (ready_k == 0 && k < 8) begin
      @(negedge clk);
      k++;
      pop_at[k]  = st_pop;
      push_at[k] = st_push;
      din_at[k]  = int'(st_data_in);
      if (cmd_if.Cmd_Ready) begin
        ready_k = k;
        cmd_if.Cmd_Valid = 1'b0;
      end else begin
        cmd_if.Cmd_Op   = 3'($urandom_range(0, 7));
        cmd_if.Cmd_Data = W'($urandom_range(0, M - 1));
      end
    end
    cmd_if.Cmd_Valid = 1'b0;
    check("ready_return_cycle", ready_k, exp_ready);
    for (int j = 1; j <= exp_ready && j <= k; j++) begin
      check($sformatf("st_pop_T+%0d", j), int'(pop_at[j]), int'(pop_mask[j]));
      check($sformatf("st_push_T+%0d", j), int'(push_at[j]), int'(push_mask[j]));
      if (push_mask[j]) check($sformatf("st_data_in_T+%0d", j), din_at[j], r);
    end
    check("depth", int'(cmd_if.Depth), ref_q.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    cmd_if.Cmd_Valid = 1'b0;
    cmd_if.Cmd_Op    = 3'd0;
    cmd_if.Cmd_Data  = '0;

    do_reset();
    do_cmd(0, 3); do_cmd(0, 5); do_cmd(1, 0);       // 3+5 = 8, depth 1
    do_cmd(7, 0);                                   // pop 8
    do_cmd(0, 2); do_cmd(0, 5); do_cmd(2, 0);       // 2-5 wraps to 13
    do_cmd(0, 6); do_cmd(3, 0);                     // 13*6 = 78 -> 14
    do_cmd(7, 0);

    for (int v = 1; v <= D; v++) do_cmd(0, v);      // fill to DEPTH
    check("full_flag", int'(st_full), 1);
    do_cmd(0, 4);                                   // overflow -> Error
    do_cmd(6, 0);                                   // 8 ^ 7 = 15 at full depth
    while (ref_q.size() > 0) do_cmd(7, 0);

    do_reset();
    do_cmd(0, 9); do_cmd(1, 0);                     // underflow -> Error
    do_cmd(7, 0); do_cmd(7, 0);                     // 9, then Error

    // Reset while in POP_A: no result, no write-back push.
    do_cmd(0, 11); do_cmd(0, 12);
    @(negedge clk);
    cmd_if.Cmd_Valid = 1'b1; cmd_if.Cmd_Op = 3'd1; cmd_if.Cmd_Data = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_if.Cmd_Valid = 1'b0;
    check("abort_pop_b", int'(st_pop), 1);
    @(negedge clk);
    check("abort_pop_a", int'(st_pop), 1);
    rst = 1'b1;
    ref_q.delete();
    held = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_reset_vals();
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(cmd_if.Cmd_Ready), 1);
    do_cmd(0, 4); do_cmd(7, 0);

    for (int n = 0; n < 250; n++) begin
      op = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 7));
      do_cmd(op, int'($urandom_range(0, M - 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
